frog_move_ctrl: RTL and testbench
=================================

Name: frog_move_ctrl

Overview:
- Player-move controller directly upstream of the per-row one-hot point registers in the Frogger matrix.
- Synchronises and edge-detects four active-low buttons plus start.
- Drives each row register's shift, load0, clear and defaultscreen controls, and shadows the frog's row and column.
- Reports win (top row reached) and lose (collision) as one-cycle pulses to the score/screen logic.

Parameters:
- DATAWIDTH, 8, columns per row; width of the one-hot point bus.
- NUM_ROWS, 8, rows on the matrix; row 0 is the bottom, NUM_ROWS-1 is the top.
- START_COL, 3, column index loaded into row 0 at game start (one-hot 8'b00001000).
- DEBOUNCE_CYCLES, 20'd500000, stable-time for buttons (used only with the optional feature).

Ports:
- SC_RegPOINTTYPE_CLOCK_50  in  1  system clock, 50 MHz.
- SC_RegPOINTTYPE_RESET_InHigh  in  1  reset; asynchronous, active-high.
- btn_left_InLow, btn_right_InLow, btn_up_InLow, btn_down_InLow  in  1 each  raw push buttons, active-low.
- start_InLow  in  1  raw start button, active-low.
- collision_InHigh  in  1  frog/car overlap flag from the crash comparator.
- defaultscreen_OutLow  out  1  broadcast to every row register.
- shiftselection_OutBUS  out  2*NUM_ROWS  per-row shift code: 01 = toward MSB, 10 = toward LSB, 00 = hold.
- load0_OutLow  out  NUM_ROWS  per-row load strobe, active-low.
- clear_OutLow  out  NUM_ROWS  per-row clear strobe, active-low.
- data0_OutBUS  out  DATAWIDTH  one-hot current column; load data for the row registers.
- row_Out  out  $clog2(NUM_ROWS)  current frog row.
- win_OutHigh, lose_OutHigh  out  1 each  one-cycle event pulses.

Behaviour:
- Reset values:
  - State WAIT_START; row_Out = 0; column = START_COL.
  - All _OutLow outputs = 1; shiftselection_OutBUS = 0.
  - win_OutHigh = 0; lose_OutHigh = 0.
- Input path:
  - Every button passes through a 2-FF synchroniser, then a falling-edge detector.
  - Result: a one-cycle press pulse, issued 3 rising edges after the pin is first sampled low.
- Press priority when several pulses coincide: up > down > left > right. Losing pulses are discarded.
- Pulses arriving in any state other than IDLE are discarded (no queueing).
- WAIT_START:
  - All strobes are inactive.
  - A start pulse moves to INIT.
- INIT (1 cycle):
  - defaultscreen_OutLow = 0.
  - row = 0; column = START_COL.
  - Next state is IDLE.
- IDLE, checked in this order:
  1. collision_InHigh = 1 → LOSE. Collision has priority over any press in the same cycle.
  2. Left pulse with column < DATAWIDTH-1 → SHIFT with code 01. If column = DATAWIDTH-1, the pulse is ignored.
  3. Right pulse with column > 0 → SHIFT with code 10. If column = 0, the pulse is ignored.
  4. Up pulse → UP_CLR.
  5. Down pulse with row > 0 → DN_CLR. If row = 0, the pulse is ignored.
- SHIFT (1 cycle):
  - shiftselection_OutBUS[2*row+1:2*row] = code; column ±1.
  - Next state is IDLE.
- UP_CLR (1 cycle):
  - clear_OutLow[row] = 0.
  - Next state is UP_LD.
- UP_LD (1 cycle):
  - load0_OutLow[row+1] = 0; data0_OutBUS = 1<<column; row += 1.
  - If the new row = NUM_ROWS-1 → WIN, else → IDLE.
- DN_CLR / DN_LD: mirror of the up sequence with row-1.
- WIN (1 cycle): win_OutHigh = 1, then → INIT, which starts a new round automatically.
- LOSE (1 cycle): lose_OutHigh = 1, then → WAIT_START.
- General output rules:
  - At most one row's strobe is active in any cycle.
  - data0_OutBUS always shows the one-hot current column.
- The column shadow must equal the target register's one-hot position at all times. The boundary checks above guarantee the register's own end-stop never triggers.
- Reset asserted mid-sequence (for example between UP_CLR and UP_LD) aborts immediately to WAIT_START with reset values. Row registers are reset by the same signal.

Optional Feature:
- Macro: FROG_DEBOUNCE_EN.
- Defined: each synchronised button feeds a debouncer. The debouncer updates its output only after the input has been stable for DEBOUNCE_CYCLES consecutive clocks, and edge detection runs on the debounced level. Press-to-command latency becomes DEBOUNCE_CYCLES+3 edges.
- Undefined: synchroniser plus edge detect only; DEBOUNCE_CYCLES is unused.

Decomposition:
- Package frog_pkg holds:
  - State encoding constants: WAIT_START, INIT, IDLE, SHIFT, UP_CLR, UP_LD, DN_CLR, DN_LD, WIN, LOSE.
  - Shift codes SHIFT_HOLD = 2'b00, SHIFT_MSB = 2'b01, SHIFT_LSB = 2'b10.
- Sub-module frog_btn_cond: synchroniser, optional debouncer and edge detector. Instantiate it five times.

Test Plan:
- Reset, then start low for 4 cycles:
  - defaultscreen_OutLow is low for exactly 1 cycle.
  - row_Out = 0; data0_OutBUS = 8'b00001000.
- From column 3, row 0, left pulse:
  - shiftselection_OutBUS[1:0] = 01 for 1 cycle; data0_OutBUS = 8'b00010000.
  - Four more left presses: the last one yields no shift, and the column stays at 8'b10000000.
- Up pulse at row 2:
  - clear_OutLow = 8'b11111011 for 1 cycle, then load0_OutLow = 8'b11110111 for 1 cycle.
  - row_Out = 3 afterwards.
- Up and left pulses in the same cycle: only the up sequence runs, with no shift. Down pulse at row 0: no strobes.
- Reach row 7:
  - win_OutHigh pulses once, then the INIT defaultscreen pulse follows.
  - Collision asserted together with an up press in IDLE: lose_OutHigh = 1, no clear/load strobes, state WAIT_START.
- Reset asserted during UP_LD:
  - All outputs return to reset values on the next sample.
  - No load0 strobe is issued after reset is released.

Source files
------------

// File: rtl/frog_pkg.sv
// Shared encodings for the Frogger player-move controller.
// States and per-row shift codes.
package frog_pkg;

  typedef enum logic [3:0] {
    WAIT_START,
    INIT,
    IDLE,
    SHIFT,
    UP_CLR,
    UP_LD,
    DN_CLR,
    DN_LD,
    WIN,
    LOSE
  } state_t;

  localparam logic [1:0] SHIFT_HOLD = 2'b00;
  localparam logic [1:0] SHIFT_MSB  = 2'b01;
  localparam logic [1:0] SHIFT_LSB  = 2'b10;

endpackage

// File: rtl/frog_btn_cond.sv
// Button conditioner: 2-FF sync, optional debounce, falling-edge pulse.
// Debounce is built only when FROG_DEBOUNCE_EN is defined.
module frog_btn_cond
  import frog_pkg::*;
`ifdef FROG_DEBOUNCE_EN
#(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
)
`endif
(
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  logic s1;
  logic s2;
  logic lvl;
  logic lvl_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

`ifdef FROG_DEBOUNCE_EN
  logic [19:0] cnt;

  // Level follows s2 only after it has differed for the full window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl <= 1'b1;
      cnt <= '0;
    end else if (s2 == lvl) begin
      cnt <= '0;
    end else if (cnt == DEBOUNCE_CYCLES - 20'd1) begin
      lvl <= s2;
      cnt <= '0;
    end else begin
      cnt <= cnt + 20'd1;
    end
  end
`else
  assign lvl = s2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_q <= 1'b1;
      press <= 1'b0;
    end else begin
      lvl_q <= lvl;
      press <= lvl_q & ~lvl;
    end
  end

endmodule

// File: rtl/frog_move_ctrl.sv
// Frogger player-move controller driving the per-row point registers.
// Optional button debouncing via FROG_DEBOUNCE_EN.
module frog_move_ctrl
  import frog_pkg::*;
#(
`ifdef FROG_DEBOUNCE_EN
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
`endif
  parameter int DATAWIDTH = 8,
  parameter int NUM_ROWS  = 8,
  parameter int START_COL = 3
) (
  input  logic SC_RegPOINTTYPE_CLOCK_50,
  input  logic SC_RegPOINTTYPE_RESET_InHigh,
  input  logic btn_left_InLow,
  input  logic btn_right_InLow,
  input  logic btn_up_InLow,
  input  logic btn_down_InLow,
  input  logic start_InLow,
  input  logic collision_InHigh,
  output logic defaultscreen_OutLow,
  output logic [2*NUM_ROWS-1:0] shiftselection_OutBUS,
  output logic [NUM_ROWS-1:0] load0_OutLow,
  output logic [NUM_ROWS-1:0] clear_OutLow,
  output logic [DATAWIDTH-1:0] data0_OutBUS,
  output logic [$clog2(NUM_ROWS)-1:0] row_Out,
  output logic win_OutHigh,
  output logic lose_OutHigh
);

  localparam int RW = $clog2(NUM_ROWS);
  localparam int CW = $clog2(DATAWIDTH);
  localparam logic [RW-1:0] TOP_ROW = RW'(NUM_ROWS - 1);
  localparam logic [CW-1:0] MAX_COL = CW'(DATAWIDTH - 1);
  localparam logic [CW-1:0] COL0 = CW'(START_COL);

  logic clk;
  logic rst;
  assign clk = SC_RegPOINTTYPE_CLOCK_50;
  assign rst = SC_RegPOINTTYPE_RESET_InHigh;

  state_t state;
  logic [CW-1:0] col;
  logic dir_msb;
  logic [4:0] btn;
  logic [4:0] press;
  logic up_p;
  logic dn_p;
  logic lf_p;
  logic rt_p;

  assign btn = {start_InLow, btn_up_InLow, btn_down_InLow,
                btn_left_InLow, btn_right_InLow};

  for (genvar i = 0; i < 5; i++) begin : g_btn
    frog_btn_cond
`ifdef FROG_DEBOUNCE_EN
      #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
      u_cond (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn[i]),
        .press(press[i])
      );
  end

  // Coincident presses: up > down > left > right, losers dropped.
  assign up_p = press[3];
  assign dn_p = press[2] & ~press[3];
  assign lf_p = press[1] & ~|press[3:2];
  assign rt_p = press[0] & ~|press[3:1];

  assign data0_OutBUS = {{(DATAWIDTH-1){1'b0}}, 1'b1} << col;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= WAIT_START;
      row_Out <= '0;
      col <= COL0;
      dir_msb <= 1'b0;
      defaultscreen_OutLow <= 1'b1;
      shiftselection_OutBUS <= {NUM_ROWS{SHIFT_HOLD}};
      load0_OutLow <= '1;
      clear_OutLow <= '1;
      win_OutHigh <= 1'b0;
      lose_OutHigh <= 1'b0;
    end else begin
      defaultscreen_OutLow <= 1'b1;
      shiftselection_OutBUS <= {NUM_ROWS{SHIFT_HOLD}};
      load0_OutLow <= '1;
      clear_OutLow <= '1;
      win_OutHigh <= 1'b0;
      lose_OutHigh <= 1'b0;
      unique case (state)
        WAIT_START: begin
          if (press[4]) begin
            state <= INIT;
            defaultscreen_OutLow <= 1'b0;
            row_Out <= '0;
            col <= COL0;
          end
        end
        INIT: state <= IDLE;
        IDLE: begin
          priority case (1'b1)
            collision_InHigh: begin
              state <= LOSE;
              lose_OutHigh <= 1'b1;
            end
            up_p: begin
              state <= UP_CLR;
              clear_OutLow[row_Out] <= 1'b0;
            end
            dn_p && (row_Out != '0): begin
              state <= DN_CLR;
              clear_OutLow[row_Out] <= 1'b0;
            end
            lf_p && (col != MAX_COL): begin
              state <= SHIFT;
              dir_msb <= 1'b1;
              shiftselection_OutBUS[{row_Out, 1'b0} +: 2] <= SHIFT_MSB;
            end
            rt_p && (col != '0): begin
              state <= SHIFT;
              dir_msb <= 1'b0;
              shiftselection_OutBUS[{row_Out, 1'b0} +: 2] <= SHIFT_LSB;
            end
            default: state <= IDLE;
          endcase
        end
        // Register shifts on this edge, so the shadow moves with it.
        SHIFT: begin
          col <= dir_msb ? col + 1'b1 : col - 1'b1;
          state <= IDLE;
        end
        UP_CLR: begin
          state <= UP_LD;
          load0_OutLow[RW'(row_Out + 1'b1)] <= 1'b0;
        end
        UP_LD: begin
          row_Out <= row_Out + 1'b1;
          if (RW'(row_Out + 1'b1) == TOP_ROW) begin
            state <= WIN;
            win_OutHigh <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        DN_CLR: begin
          state <= DN_LD;
          load0_OutLow[RW'(row_Out - 1'b1)] <= 1'b0;
        end
        DN_LD: begin
          row_Out <= row_Out - 1'b1;
          state <= IDLE;
        end
        WIN: begin
          state <= INIT;
          defaultscreen_OutLow <= 1'b0;
          row_Out <= '0;
          col <= COL0;
        end
        LOSE: state <= WAIT_START;
        default: state <= WAIT_START;
      endcase
    end
  end

endmodule

// File: tb/tb_frog_move_ctrl.sv
// Self-checking bench for frog_move_ctrl: vector table, random
// actions against a game-level model, and a mid-sequence reset.
module tb_frog_move_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic b_left = 1'b1, b_right = 1'b1;
  logic b_up = 1'b1, b_down = 1'b1, b_start = 1'b1;
  logic coll_in = 1'b0;
  logic ds;
  logic [15:0] shsel;
  logic [7:0] load0, clr, data0;
  logic [2:0] row;
  logic win, lose;

  always #10 clk = ~clk;

  frog_move_ctrl dut (
    .SC_RegPOINTTYPE_CLOCK_50(clk),
    .SC_RegPOINTTYPE_RESET_InHigh(rst),
    .btn_left_InLow(b_left),
    .btn_right_InLow(b_right),
    .btn_up_InLow(b_up),
    .btn_down_InLow(b_down),
    .start_InLow(b_start),
    .collision_InHigh(coll_in),
    .defaultscreen_OutLow(ds),
    .shiftselection_OutBUS(shsel),
    .load0_OutLow(load0),
    .clear_OutLow(clr),
    .data0_OutBUS(data0),
    .row_Out(row),
    .win_OutHigh(win),
    .lose_OutHigh(lose)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Observed events within one action window.
  int cyc, n_sh, n_clr, n_ld, n_win, n_lose, n_ds;
  int clr_cyc, ld_cyc, win_cyc, ds_cyc;
  logic [15:0] sh_val;
  logic [7:0] clr_val, ld_val;

  // Game-level model.
  bit m_act;
  int m_row, m_col;
  int e_sh, e_clr, e_win, e_lose, e_ds;
  logic [15:0] e_shv;
  logic [7:0] e_clrv, e_ldv;

  typedef struct {
    logic [4:0] mask;
    bit coll;
    int row;
    int col;
    int nsh;
    int win;
    int lose;
  } vec_t;
  vec_t tbl[$];

  localparam logic [4:0] ST = 5'b10000;
  localparam logic [4:0] U = 5'b01000;
  localparam logic [4:0] D = 5'b00100;
  localparam logic [4:0] L = 5'b00010;
  localparam logic [4:0] R = 5'b00001;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic clear_mon();
    n_sh = 0; n_clr = 0; n_ld = 0;
    n_win = 0; n_lose = 0; n_ds = 0;
    clr_cyc = -1; ld_cyc = -1; win_cyc = -1; ds_cyc = -1;
    sh_val = '0; clr_val = '1; ld_val = '1;
  endtask

  task automatic sample();
    int s;
    @(negedge clk);
    cyc++;
    s = 0;
    for (int i = 0; i < 8; i++) begin
      if (!clr[i]) s++;
      if (!load0[i]) s++;
      if (shsel[2*i +: 2] != 2'b00) s++;
    end
    chk("one_strobe", 32'(s <= 1), 1);
    chk("data0_onehot", 32'($onehot(data0)), 1);
    if (!ds) begin n_ds++; ds_cyc = cyc; end
    if (shsel != '0) begin n_sh++; sh_val = shsel; end
    if (clr != '1) begin n_clr++; clr_val = clr; clr_cyc = cyc; end
    if (load0 != '1) begin n_ld++; ld_val = load0; ld_cyc = cyc; end
    if (win) begin n_win++; win_cyc = cyc; end
    if (lose) begin n_lose++; end
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_ds"}, ds, 1);
    chk({tag, "_shsel"}, shsel, 0);
    chk({tag, "_load0"}, load0, 8'hff);
    chk({tag, "_clear"}, clr, 8'hff);
    chk({tag, "_row"}, row, 0);
    chk({tag, "_data0"}, data0, 8'h08);
    chk({tag, "_win"}, win, 0);
    chk({tag, "_lose"}, lose, 0);
  endtask

  task automatic model_act(logic [4:0] mask, bit coll);
    logic [7:0] b8;
    logic [15:0] b16;
    b8 = 8'd1;
    e_sh = 0; e_clr = 0; e_win = 0; e_lose = 0; e_ds = 0;
    e_shv = '0; e_clrv = '1; e_ldv = '1;
    if (!m_act) begin
      if (mask[4]) begin
        m_act = 1; e_ds = 1; m_row = 0; m_col = 3;
      end
    end else if (coll) begin
      e_lose = 1; m_act = 0;
    end else if (mask[3]) begin
      e_clr = 1;
      e_clrv = ~(b8 << m_row);
      e_ldv = ~(b8 << (m_row + 1));
      m_row++;
      if (m_row == 7) begin
        e_win = 1; e_ds = 1; m_row = 0; m_col = 3;
      end
    end else if (mask[2]) begin
      if (m_row > 0) begin
        e_clr = 1;
        e_clrv = ~(b8 << m_row);
        e_ldv = ~(b8 << (m_row - 1));
        m_row--;
      end
    end else if (mask[1]) begin
      if (m_col < 7) begin
        b16 = 16'b01;
        e_sh = 1; e_shv = b16 << (2 * m_row); m_col++;
      end
    end else if (mask[0]) begin
      if (m_col > 0) begin
        b16 = 16'b10;
        e_sh = 1; e_shv = b16 << (2 * m_row); m_col--;
      end
    end
  endtask

  task automatic check_window(string tag);
    logic [7:0] b8;
    b8 = 8'd1;
    chk({tag, "_nshift"}, n_sh, e_sh);
    chk({tag, "_nclear"}, n_clr, e_clr);
    chk({tag, "_nload"}, n_ld, e_clr);
    chk({tag, "_nwin"}, n_win, e_win);
    chk({tag, "_nlose"}, n_lose, e_lose);
    chk({tag, "_nds"}, n_ds, e_ds);
    chk({tag, "_row"}, row, m_row);
    chk({tag, "_data0"}, data0, b8 << m_col);
    if (e_sh != 0) chk({tag, "_shbus"}, sh_val, e_shv);
    if (e_clr != 0) begin
      chk({tag, "_clrbus"}, clr_val, e_clrv);
      chk({tag, "_ldbus"}, ld_val, e_ldv);
      chk({tag, "_ld_after_clr"}, ld_cyc, clr_cyc + 1);
    end
    if (e_win != 0) chk({tag, "_ds_after_win"}, ds_cyc, win_cyc + 1);
  endtask

  // Hold buttons 4 cycles; collision lines up with the press pulse.
  task automatic act(logic [4:0] mask, bit coll, string tag);
    clear_mon();
    {b_start, b_up, b_down, b_left, b_right} = ~mask;
    for (int i = 1; i <= 12; i++) begin
      sample();
      coll_in = coll && (i == 3);
      if (i == 4) {b_start, b_up, b_down, b_left, b_right} = 5'h1f;
    end
    model_act(mask, coll);
    check_window(tag);
  endtask

  initial begin
    bit seen;
    logic [4:0] mask;
    bit coll;
    logic [7:0] b8;
    b8 = 8'd1;
    cyc = 0;
    m_act = 0; m_row = 0; m_col = 3;
    clear_mon();

    repeat (3) sample();
    chk_reset("rst_in");
    rst = 1'b0;
    sample();
    chk_reset("rst_out");

    act(ST, 0, "start");
    chk("start_ds_once", n_ds, 1);
    chk("start_row", row, 0);
    chk("start_data0", data0, 8'h08);

    tbl.push_back('{L, 0, 0, 4, 1, 0, 0});
    tbl.push_back('{L, 0, 0, 5, 1, 0, 0});
    tbl.push_back('{L, 0, 0, 6, 1, 0, 0});
    tbl.push_back('{L, 0, 0, 7, 1, 0, 0});
    tbl.push_back('{L, 0, 0, 7, 0, 0, 0});
    tbl.push_back('{R, 0, 0, 6, 1, 0, 0});
    tbl.push_back('{U, 0, 1, 6, 0, 0, 0});
    tbl.push_back('{U, 0, 2, 6, 0, 0, 0});
    tbl.push_back('{U, 0, 3, 6, 0, 0, 0});
    tbl.push_back('{U | L, 0, 4, 6, 0, 0, 0});
    tbl.push_back('{D, 0, 3, 6, 0, 0, 0});
    tbl.push_back('{D, 0, 2, 6, 0, 0, 0});
    tbl.push_back('{D, 0, 1, 6, 0, 0, 0});
    tbl.push_back('{D, 0, 0, 6, 0, 0, 0});
    tbl.push_back('{D, 0, 0, 6, 0, 0, 0});
    tbl.push_back('{D | R, 0, 0, 6, 0, 0, 0});
    for (int r = 1; r <= 6; r++) tbl.push_back('{U, 0, r, 6, 0, 0, 0});
    tbl.push_back('{U, 0, 0, 3, 0, 1, 0});
    tbl.push_back('{U, 1, 0, 3, 0, 0, 1});
    tbl.push_back('{U, 0, 0, 3, 0, 0, 0});
    tbl.push_back('{ST | R, 0, 0, 3, 0, 0, 0});

    foreach (tbl[i]) begin
      act(tbl[i].mask, tbl[i].coll, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_trow", i), row, tbl[i].row);
      chk($sformatf("vec%0d_tcol", i), data0, b8 << tbl[i].col);
      chk($sformatf("vec%0d_tnsh", i), n_sh, tbl[i].nsh);
      chk($sformatf("vec%0d_twin", i), n_win, tbl[i].win);
      chk($sformatf("vec%0d_tlose", i), n_lose, tbl[i].lose);
    end

    for (int k = 0; k < 60; k++) begin
      mask = 5'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0 || !m_act) mask[4] = 1'b1;
      coll = ($urandom_range(0, 7) == 0);
      act(mask, coll, $sformatf("rnd%0d", k));
    end

    if (!m_act) act(ST, 0, "restart");
    clear_mon();
    b_up = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      sample();
      if (clr != '1) seen = 1;
    end
    chk("upclr_seen", 32'(seen), 1);
    if (seen) begin
      @(posedge clk);
      #2 rst = 1'b1;
      sample();
      chk_reset("rst_upld");
      b_up = 1'b1;
      sample();
      rst = 1'b0;
      clear_mon();
      repeat (10) sample();
      chk("rst_no_load", n_ld, 0);
      chk("rst_row", row, 0);
      m_act = 0; m_row = 0; m_col = 3;
      act(U, 0, "post_rst_up");
    end
    b_up = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
